// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding, counter width, clog2 helper.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int unsigned BEAT_CNT_W = 8;

  // Minimum of 1 so a grant index always has at least one bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester above last_gnt, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned GNT_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [GNT_WIDTH-1:0] last_gnt,
  output logic [GNT_WIDTH-1:0] winner,
  output logic                 valid
);

  localparam int unsigned SUM_W = GNT_WIDTH + 1;

  logic [GNT_WIDTH-1:0] start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [GNT_WIDTH-1:0] ofs;
  logic                 found;
  logic [SUM_W-1:0]     sum;

  // Rotate so the search starts just above last_gnt, priority-encode, then unrotate
  always_comb begin
    start = (last_gnt == GNT_WIDTH'(NUM_REQ - 1)) ? '0 : last_gnt + GNT_WIDTH'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    ofs   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        ofs   = GNT_WIDTH'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, ofs};
    if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
    winner = sum[GNT_WIDTH-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to allow up to MAX_BURST beats per grant; otherwise one beat per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned GNT_WIDTH  = clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  input  logic                            fifo_full,
  output logic                            fifo_ws,
  output logic                            fifo_we,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic [GNT_WIDTH-1:0]            grant_id,
  output logic                            busy
);

`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  localparam int unsigned            BURST_LIM = BURST_EN ? MAX_BURST : 1;
  localparam logic [BEAT_CNT_W-1:0]  CNT_LAST  = BEAT_CNT_W'(BURST_LIM);

  logic [0:0]            state, state_nxt;
  logic [GNT_WIDTH-1:0]  grant_nxt, last_gnt, last_nxt;
  logic [GNT_WIDTH-1:0]  pick_idx;
  logic                  pick_vld;
  logic [BEAT_CNT_W-1:0] beat_cnt, cnt_nxt;
  logic                  req_sel;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .GNT_WIDTH (GNT_WIDTH)
  ) u_picker (
    .req      (req),
    .last_gnt (last_gnt),
    .winner   (pick_idx),
    .valid    (pick_vld)
  );

  // Select the granted producer's request and data
  always_comb begin
    req_sel  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GNT_WIDTH'(i)) begin
        req_sel  = req[i];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign beat    = (state == ST_XFER) && req_sel && !fifo_full;
  assign fifo_ws = beat;
  assign fifo_we = beat;
  assign busy    = (state == ST_XFER);

  // Data and ack are forced to zero whenever no beat fires
  always_comb begin
    ack       = '0;
    fifo_data = '0;
    if (beat) begin
      ack       = NUM_REQ'(1) << grant_id;
      fifo_data = sel_data;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_gnt;
    cnt_nxt   = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_vld && !fifo_full) begin
          state_nxt = ST_XFER;
          grant_nxt = pick_idx;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ST_XFER: begin
        // A stall with req held keeps the grant; dropping req releases it
        if (!req_sel) begin
          state_nxt = ST_IDLE;
        end else if (beat) begin
          cnt_nxt = beat_cnt + BEAT_CNT_W'(1);
          if (cnt_nxt == CNT_LAST) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      last_gnt <= GNT_WIDTH'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_gnt <= last_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expectations adapt to FIFO_ARB_BURST_EN (4 or 1 beat per grant).
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int BL = 4;
`else
  localparam int BL = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = 32'hD3C2_B1A0;
  logic [31:0] rdata = 32'hD3C2_B1A0;
  logic [3:0]  ack;
  logic        fifo_full = 1'b0;
  logic        fifo_ws, fifo_we;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_v;
  logic [14:0] exp_i;

  wire [16:0] obs_beat = {busy, grant_id, ack, fifo_ws, fifo_we, fifo_data};
  wire [14:0] obs_idle = {busy, ack, fifo_ws, fifo_we, fifo_data};

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4),
    .GNT_WIDTH  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_ws   (fifo_ws),
    .fifo_we   (fifo_we),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    req       = '0;
    fifo_full = 1'b0;
    reset     = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    step;
    n_tests++;
    exp_v = 17'h0;
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", obs_beat, exp_v);
    end
    reset = 1'b0;
    req = 4'b0001;
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd0, 4'b0001, 2'b11, rdata[7:0]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL reset_pre_beat1 got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    #1;
    n_tests++;
    exp_v = (BL > 1) ? {1'b1, 2'd0, 4'b0001, 2'b11, rdata[7:0]} : 17'h0;
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL reset_pre_beat2 got=%h exp=%h", obs_beat, exp_v);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    exp_v = 17'h0;
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    reset = 1'b0;
    req = 4'b0011;
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd0, 4'b0001, 2'b11, rdata[7:0]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL reset_first_grant got=%h exp=%h", obs_beat, exp_v);
    end
  endtask

  task automatic test_round_robin;
    int g;
    do_reset;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      #1;
      n_tests++;
      exp_i = 15'h0;
      if (obs_idle !== exp_i) begin
        n_fail++;
        $display("FAIL rr_idle k=%0d got=%h exp=%h", k, obs_idle, exp_i);
      end
      step;
      for (int b = 0; b < BL; b++) begin
        #1;
        n_tests++;
        exp_v = {1'b1, 2'(g), 4'(1 << g), 2'b11, rdata[g*8 +: 8]};
        if (obs_beat !== exp_v) begin
          n_fail++;
          $display("FAIL rr_beat k=%0d b=%0d got=%h exp=%h", k, b, obs_beat, exp_v);
        end
        step;
      end
    end
  endtask

  task automatic test_stall;
    int nacks;
    do_reset;
    req = 4'b0100;
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd2, 4'b0100, 2'b11, rdata[23:16]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL stall_beat1 got=%h exp=%h", obs_beat, exp_v);
    end
    nacks = int'(ack[2]);
    step;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      exp_v = {1'(BL > 1), 2'd2, 14'h0};
      if (obs_beat !== exp_v) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d got=%h exp=%h", c, obs_beat, exp_v);
      end
      nacks += int'(ack[2]);
      step;
    end
    fifo_full = 1'b0;
    for (int b = 1; b < BL; b++) begin
      #1;
      n_tests++;
      exp_v = {1'b1, 2'd2, 4'b0100, 2'b11, rdata[23:16]};
      if (obs_beat !== exp_v) begin
        n_fail++;
        $display("FAIL stall_resume b=%0d got=%h exp=%h", b, obs_beat, exp_v);
      end
      nacks += int'(ack[2]);
      step;
    end
    #1;
    n_tests++;
    exp_i = 15'h0;
    if (obs_idle !== exp_i) begin
      n_fail++;
      $display("FAIL stall_release got=%h exp=%h", obs_idle, exp_i);
    end
    n_tests++;
    if (nacks !== BL) begin
      n_fail++;
      $display("FAIL stall_beat_count got=%0d exp=%0d", nacks, BL);
    end
  endtask

  task automatic test_req_drop;
    do_reset;
    req = 4'b0110;
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd1, 4'b0010, 2'b11, rdata[15:8]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL drop_beat1 got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    #1;
    n_tests++;
    exp_v = (BL > 1) ? {1'b1, 2'd1, 4'b0010, 2'b11, rdata[15:8]} : {1'b0, 2'd1, 14'h0};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL drop_beat2 got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    req = 4'b0100;
    #1;
    n_tests++;
    exp_v = (BL > 1) ? {1'b1, 2'd1, 14'h0} : {1'b1, 2'd2, 4'b0100, 2'b11, rdata[23:16]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL drop_cycle got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    #1;
    n_tests++;
    exp_v = {1'b0, 2'((BL > 1) ? 1 : 2), 14'h0};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL drop_idle got=%h exp=%h", obs_beat, exp_v);
    end
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd2, 4'b0100, 2'b11, rdata[23:16]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL drop_next_grant got=%h exp=%h", obs_beat, exp_v);
    end
  endtask

  task automatic test_interleave;
    int g;
    do_reset;
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2) * 2;
      #1;
      n_tests++;
      exp_i = 15'h0;
      if (obs_idle !== exp_i) begin
        n_fail++;
        $display("FAIL il_idle k=%0d got=%h exp=%h", k, obs_idle, exp_i);
      end
      step;
      for (int b = 0; b < BL; b++) begin
        #1;
        n_tests++;
        exp_v = {1'b1, 2'(g), 4'(1 << g), 2'b11, rdata[g*8 +: 8]};
        if (obs_beat !== exp_v) begin
          n_fail++;
          $display("FAIL il_beat k=%0d b=%0d got=%h exp=%h", k, b, obs_beat, exp_v);
        end
        step;
      end
    end
  endtask

  task automatic test_full_idle;
    do_reset;
    fifo_full = 1'b1;
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step;
      #1;
      n_tests++;
      exp_v = {1'b0, 2'd0, 14'h0};
      if (obs_beat !== exp_v) begin
        n_fail++;
        $display("FAIL full_idle c=%0d got=%h exp=%h", c, obs_beat, exp_v);
      end
    end
    fifo_full = 1'b0;
    step;
    #1;
    n_tests++;
    exp_v = {1'b1, 2'd3, 4'b1000, 2'b11, rdata[31:24]};
    if (obs_beat !== exp_v) begin
      n_fail++;
      $display("FAIL full_release_grant got=%h exp=%h", obs_beat, exp_v);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_stall;
    test_req_drop;
    test_interleave;
    test_full_idle;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
